// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// controller state encoding and the hard-wired zero register index.
package pipe_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } pipe_state_e;

  // EX/MEM result is younger than MEM/WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       exmem_we,
                                         input logic [4:0] exmem_rd,
                                         input logic       memwb_we,
                                         input logic [4:0] memwb_rd);
    logic [1:0] sel;
    sel = FWD_REG;
    if (exmem_we && (exmem_rd != REG_ZERO) && (exmem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (memwb_we && (memwb_rd != REG_ZERO) && (memwb_rd == src)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Combinational ALU operand forwarding selects for both EX-stage source operands.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] idex_rs_i,
  input  logic [4:0] idex_rt_i,
  input  logic       exmem_reg_write_i,
  input  logic [4:0] exmem_rd_i,
  input  logic       memwb_reg_write_i,
  input  logic [4:0] memwb_rd_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  always_comb begin
    fwd_a_o = fwd_sel(idex_rs_i, exmem_reg_write_i, exmem_rd_i, memwb_reg_write_i, memwb_rd_i);
    fwd_b_o = fwd_sel(idex_rt_i, exmem_reg_write_i, exmem_rd_i, memwb_reg_write_i, memwb_rd_i);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: memory-wait freeze, branch squash,
// load-use bubble and forwarding. Optional perf counters enabled by PIPE_PERF_CNT_EN.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_LAT = 0,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic [4:0]  idex_rs,
  input  logic [4:0]  idex_rt,
  input  logic        idex_mem_read,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic        exmem_mem_acc,
  input  logic        exmem_br_taken,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
  output logic [31:0] squashed_insts,
`endif
  output logic        state_o
);

  pipe_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_done_q, acc_done_d;
  logic             hold_start, hold, br_flush, load_use;

  fwd_unit u_fwd_unit (
    .idex_rs_i        (idex_rs),
    .idex_rt_i        (idex_rt),
    .exmem_reg_write_i(exmem_reg_write),
    .exmem_rd_i       (exmem_rd),
    .memwb_reg_write_i(memwb_reg_write),
    .memwb_rd_i       (memwb_rd),
    .fwd_a_o          (fwd_a),
    .fwd_b_o          (fwd_b)
  );

  always_comb begin
    hold_start = (state_q == ST_RUN) && exmem_mem_acc && !acc_done_q && (MEM_LAT > 0);
    hold       = hold_start || (state_q == ST_WAIT);
    br_flush   = !hold && exmem_br_taken;
    load_use   = !hold && !br_flush && idex_mem_read && (idex_rt != REG_ZERO) &&
                 ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (hold) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (br_flush) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_done_d = acc_done_q;
    // A completed access stays "done" until the instruction leaves EX/MEM.
    if (exmem_en) acc_done_d = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (hold_start) begin
          if (MEM_LAT == 1) begin
            acc_done_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(MEM_LAT - 1);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d    = ST_RUN;
          acc_done_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      acc_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_done_q <= acc_done_d;
    end
  end

  assign state_o = (state_q == ST_WAIT);

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_events_q, squashed_insts_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q   <= '0;
      flush_events_q   <= '0;
      squashed_insts_q <= '0;
    end else begin
      if (hold || load_use) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (br_flush) begin
        flush_events_q   <= flush_events_q + 32'd1;
        squashed_insts_q <= squashed_insts_q + 32'd3;
      end
    end
  end

  assign stall_cycles   = stall_cycles_q;
  assign flush_events   = flush_events_q;
  assign squashed_insts = squashed_insts_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl (MEM_LAT=3): directed hazard scenarios then random traffic.
module tb_pipeline_ctrl;

  localparam int unsigned LAT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, exmem_rd, memwb_rd;
  logic       idex_mem_read, exmem_reg_write, exmem_mem_acc, exmem_br_taken, memwb_reg_write;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, state_o;
  logic [1:0] fwd_a, fwd_b;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events, squashed_insts;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_LAT(LAT), .CNT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ifid_rs        (ifid_rs),
    .ifid_rt        (ifid_rt),
    .idex_rs        (idex_rs),
    .idex_rt        (idex_rt),
    .idex_mem_read  (idex_mem_read),
    .exmem_reg_write(exmem_reg_write),
    .exmem_rd       (exmem_rd),
    .exmem_mem_acc  (exmem_mem_acc),
    .exmem_br_taken (exmem_br_taken),
    .memwb_reg_write(memwb_reg_write),
    .memwb_rd       (memwb_rd),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .idex_en        (idex_en),
    .exmem_en       (exmem_en),
    .memwb_en       (memwb_en),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .exmem_flush    (exmem_flush),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
`ifdef PIPE_PERF_CNT_EN
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events),
    .squashed_insts (squashed_insts),
`endif
    .state_o        (state_o)
  );

  logic [12:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: position inside the current freeze, not a state encoding.
  bit          m_in_hold = 1'b0;
  int          m_idx = 0;
  bit          m_served = 1'b0;
  logic [31:0] m_stall = 0, m_flush = 0, m_squash = 0;

  wire [12:0] act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                     ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b, state_o};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [12:0] e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL outputs t=%0t actual=%b required=%b (en5 fl3 fa fb st)", $time, act, e);
      end
    end
  end

  function automatic logic [1:0] ref_fwd(input logic [4:0] r);
    if (r == 5'd0) return 2'b00;
    if (exmem_reg_write && exmem_rd == r) return 2'b10;
    if (memwb_reg_write && memwb_rd == r) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clr();
    {ifid_rs, ifid_rt, idex_rs, idex_rt, exmem_rd, memwb_rd} = '0;
    {idex_mem_read, exmem_reg_write, exmem_mem_acc, exmem_br_taken, memwb_reg_write} = '0;
  endtask

  task automatic step(input bit chk);
    bit hold, br, lu;
    int idx;
    logic [1:0] fa, fb;
    logic [12:0] e;
    hold = m_in_hold || (exmem_mem_acc && !m_served && LAT > 0);
    idx  = m_in_hold ? m_idx : 0;
    br   = !hold && exmem_br_taken;
    lu   = !hold && !br && idex_mem_read && idex_rt != 0 &&
           (idex_rt == ifid_rs || idex_rt == ifid_rt);
    fa = ref_fwd(idex_rs);
    fb = ref_fwd(idex_rt);
    if (hold)    e = {5'b00000, 3'b000, fa, fb, (idx > 0) ? 1'b1 : 1'b0};
    else if (br) e = {5'b11111, 3'b111, fa, fb, 1'b0};
    else if (lu) e = {5'b00111, 3'b010, fa, fb, 1'b0};
    else         e = {5'b11111, 3'b000, fa, fb, 1'b0};
    if (chk) exp_q.push_back(e);
    @(posedge clk);
    if (!rst_n) begin
      m_in_hold = 0; m_idx = 0; m_served = 0;
      m_stall = 0; m_flush = 0; m_squash = 0;
    end else begin
      if (hold || lu) m_stall = m_stall + 1;
      if (br) begin
        m_flush  = m_flush + 1;
        m_squash = m_squash + 3;
      end
      if (hold) begin
        if (idx + 1 == LAT) begin
          m_in_hold = 0; m_served = 1;
        end else begin
          m_in_hold = 1; m_idx = idx + 1;
        end
      end else begin
        m_served = 0;
      end
    end
    #1;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    #1;
    step(0);
    step(1);
    rst_n = 1'b1;
    step(1);
    // Forwarding: EX/MEM priority, register 0, MEM/WB on rt
    exmem_reg_write = 1; exmem_rd = 5; idex_rs = 5; memwb_reg_write = 1; memwb_rd = 5;
    step(1);
    exmem_rd = 0; idex_rs = 0; memwb_rd = 0;
    step(1);
    memwb_rd = 7; idex_rt = 7;
    step(1);
    clr();
    // Load-use stall, then bubble clears it
    idex_mem_read = 1; idex_rt = 8; ifid_rt = 8;
    step(1);
    idex_mem_read = 0;
    step(1);
    // Branch overrides load-use
    idex_mem_read = 1; exmem_br_taken = 1;
    step(1);
    clr();
    step(1);
    // Memory wait, then a second load right behind
    exmem_mem_acc = 1;
    repeat (LAT + 1 + LAT) step(1);
    exmem_mem_acc = 0;
    step(1);
    // Taken branch that also needs a memory hold
    exmem_mem_acc = 1; exmem_br_taken = 1;
    repeat (LAT + 1) step(1);
    clr();
    step(1);
    // Reset during WAIT abandons the freeze; next access gets a full hold
    exmem_mem_acc = 1;
    step(1);
    rst_n = 0;
    step(1);
    rst_n = 1;
    repeat (LAT + 1) step(1);
    clr();
    step(1);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      ifid_rs = 5'($urandom_range(0, 3));
      ifid_rt = 5'($urandom_range(0, 3));
      idex_rs = 5'($urandom_range(0, 3));
      idex_rt = 5'($urandom_range(0, 3));
      exmem_rd = 5'($urandom_range(0, 3));
      memwb_rd = 5'($urandom_range(0, 3));
      idex_mem_read   = ($urandom_range(0, 1) == 1);
      exmem_reg_write = ($urandom_range(0, 1) == 1);
      memwb_reg_write = ($urandom_range(0, 1) == 1);
      exmem_mem_acc   = ($urandom_range(0, 3) == 0);
      exmem_br_taken  = ($urandom_range(0, 5) == 0);
      rst_n           = ($urandom_range(0, 59) != 0);
      step(1);
    end
    clr();
    rst_n = 1;
    step(1);
    step(1);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (stall_cycles !== m_stall) begin
      failures++;
      $display("FAIL stall_cycles actual=%0d required=%0d", stall_cycles, m_stall);
    end
    checks++;
    if (flush_events !== m_flush) begin
      failures++;
      $display("FAIL flush_events actual=%0d required=%0d", flush_events, m_flush);
    end
    checks++;
    if (squashed_insts !== m_squash) begin
      failures++;
      $display("FAIL squashed_insts actual=%0d required=%0d", squashed_insts, m_squash);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
